// File: rtl/fetch_pkg.sv
// fetch_pkg: Y86-64 icode constants, fetch state encoding and the "no register" id.
package fetch_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  typedef enum logic [1:0] {IDLE, FETCH0, FETCHN, DONE} state_t;
endpackage

// File: rtl/instr_length_decode.sv
// instr_length_decode: icode -> instruction length, register-byte presence, valC byte offset, invalid flag.
module instr_length_decode
  import fetch_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] length,
  output logic       has_regs,
  output logic [3:0] valc_offset,
  output logic       invalid
);
  always_comb begin
    length = 4'd1;
    has_regs = 1'b0;
    valc_offset = 4'd0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        length = 4'd2;
        has_regs = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        length = 4'd10;
        has_regs = 1'b1;
        valc_offset = 4'd2;
      end
      I_JXX, I_CALL: begin
        length = 4'd9;
        valc_offset = 4'd1;
      end
      default: ;
    endcase
  end
  assign invalid = icode > I_POPQ;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle Y86-64 byte-serial instruction fetch with valid/ready output.
// Define FETCH_TIMEOUT_EN to abort a fetch when mem_ack does not arrive within TIMEOUT_CYCLES.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc_in,
  output logic        busy,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_invalid,
  output logic        imem_error
);
  state_t      state;
  logic [63:0] base;
  logic [3:0]  idx, len, valc_off, dec_len, dec_off, cur_len;
  logic        has_regs, dec_regs, dec_invalid, ack, fault, timeout, last;
  logic [2:0]  cbyte;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  instr_length_decode u_dec (
    .icode(mem_rdata[7:4]),
    .length(dec_len),
    .has_regs(dec_regs),
    .valc_offset(dec_off),
    .invalid(dec_invalid)
  );

  assign ack = mem_req && mem_ack;
  assign fault = (ack && mem_err) || timeout;
  assign cur_len = state == FETCH0 ? dec_len : len;
  assign last = idx == cur_len - 4'd1;
  assign cbyte = 3'(idx - valc_off);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  assign timeout = mem_req && !mem_ack && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
  // mem_req is low in IDLE/DONE and every state change is an ack, so this also clears on state entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (!mem_req || mem_ack || timeout) ? '0 : wait_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      idx <= '0;
      len <= 4'd1;
      valc_off <= '0;
      has_regs <= 1'b0;
      busy <= 1'b0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      out_valid <= 1'b0;
      icode <= I_NOP;
      ifun <= '0;
      rA <= REG_NONE;
      rB <= REG_NONE;
      valC <= '0;
      valP <= '0;
      instr_invalid <= 1'b0;
      imem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FETCH0;
          base <= pc_in;
          idx <= '0;
          busy <= 1'b1;
          mem_req <= 1'b1;
          mem_addr <= pc_in;
          rA <= REG_NONE;
          rB <= REG_NONE;
          valC <= '0;
          instr_invalid <= 1'b0;
          imem_error <= 1'b0;
        end
        FETCH0, FETCHN: if (fault) begin
          state <= DONE;
          mem_req <= 1'b0;
          out_valid <= 1'b1;
          imem_error <= 1'b1;
          valP <= base + 64'd1;
        end else if (ack) begin
          if (state == FETCH0) begin
            icode <= mem_rdata[7:4];
            ifun <= mem_rdata[3:0];
            len <= dec_len;
            has_regs <= dec_regs;
            valc_off <= dec_off;
            instr_invalid <= dec_invalid;
          end else if (has_regs && idx == 4'd1) begin
            rA <= mem_rdata[7:4];
            rB <= mem_rdata[3:0];
          end else begin
            valC[{cbyte, 3'b000} +: 8] <= mem_rdata;
          end
          if (last) begin
            state <= DONE;
            mem_req <= 1'b0;
            out_valid <= 1'b1;
            valP <= base + 64'(cur_len);
          end else begin
            state <= FETCHN;
            idx <= idx + 4'd1;
            mem_addr <= base + 64'(idx + 4'd1);
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          busy <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle Y86-64 instruction fetch unit. It consumes the PC produced by the PC-selection logic. It reads instruction bytes one per transfer from a byte-wide instruction memory over a req/ack handshake, assembles icode/ifun/rA/rB/valC, and computes valP. Results go to decode through a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may wait for mem_ack before a fetch error (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a fetch at pc_in; accepted only when busy=0
pc_in  input  64  fetch address, sampled when start is accepted
busy  output  1  high from start acceptance until the output is accepted
mem_req  output  1  byte read request
mem_addr  output  64  byte address, stable while mem_req=1
mem_ack  input  1  read complete; mem_rdata valid this cycle
mem_rdata  input  8  read byte
mem_err  input  1  qualified by mem_ack; address fault
out_valid  output  1  fetched instruction available
out_ready  input  1  decode accepts the instruction
icode  output  4  instruction code
ifun  output  4  function code
rA  output  4  register A (4'hF if absent)
rB  output  4  register B (4'hF if absent)
valC  output  64  constant (0 if absent)
valP  output  64  pc_in + instruction length
instr_invalid  output  1  icode > 4'hB
imem_error  output  1  memory fault (or timeout) during fetch

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, mem_req, out_valid, instr_invalid, imem_error = 0; mem_addr, valC, valP = 0; icode = 4'h1 (nop); ifun = 0; rA = rB = 4'hF.
- States: IDLE -> FETCH0 -> FETCHN -> DONE -> IDLE.
- IDLE: start=1 latches pc_in into the base register and the byte counter (idx=0), then goes to FETCH0. busy=1 from the next cycle. start is ignored while busy=1.
- FETCH0: mem_req=1, mem_addr=base.
  - On mem_ack, latch icode=rdata[7:4] and ifun=rdata[3:0], and look up the length.
  - Length table: 0,1,9 -> 1; 2,6,A,B -> 2; 3,4,5 -> 10; 7,8 -> 9; icode > B -> invalid, length 1.
  - If length=1, go to DONE; otherwise go to FETCHN with idx=1.
- FETCHN: mem_addr=base+idx (64-bit wrap). Each mem_ack stores byte idx, then increments idx.
  - Formats 2/10: byte1 = rA:rB.
  - Format 10: bytes 2..9 = valC, little-endian.
  - Format 9: bytes 1..8 = valC, little-endian.
  - After the last byte, go to DONE.
- mem_req deasserts in the cycle after the final ack; between bytes it may stay high. One byte is transferred per ack cycle; back-to-back acks must be supported.
- mem_ack with mem_err=1 in any fetch state: imem_error=1, go straight to DONE. Fields latched so far are kept; remaining fields keep their defaults.
- DONE: out_valid=1, all outputs held stable, valP=base+length (wraps modulo 2^64; on error, valP=base+1).
  - out_valid && out_ready -> IDLE with busy=0, out_valid=0.
  - A new start is possible the following cycle.
- Field defaults are reloaded at each start acceptance: rA = rB = F, valC = 0, instr_invalid = 0, imem_error = 0.
- mem_ack while mem_req=0 is ignored.
- Reset mid-fetch aborts immediately; the memory side must tolerate the dropped request.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: a wait counter clears on every ack and on every state entry, and increments each cycle that mem_req=1 && !mem_ack. When it reaches TIMEOUT_CYCLES, the block sets imem_error=1, drops mem_req, and goes to DONE. A late ack is then ignored.
- Undefined: no counter; the block waits indefinitely for ack; TIMEOUT_CYCLES is unused.

Decomposition:
- Package fetch_pkg holds:
  - icode constants (I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ);
  - the state enum typedef;
  - default register id REG_NONE=4'hF.
- One combinational sub-module, instr_length_decode: icode -> length[3:0], has_regs, valc_offset, invalid.

Test Plan:
- irmovq at pc=0x100, bytes 30 F3 EF CD AB 89 67 45 23 01, zero-wait acks -> icode=3, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=0x10A, out_valid after 10 acks.
- call at pc=0x40, bytes 80 00 02 00 00 00 00 00 00 -> valC=0x200, rA=rB=F, valP=0x49.
- ret (90) then addq (60 23) back-to-back, out_ready held low 3 cycles on the first -> outputs stable while stalled; second result: ifun=0, rA=2, rB=3, valP=pc+2.
- Byte 0xC0 -> instr_invalid=1, valP=pc+1, single memory read.
- mrmovq with mem_err on byte 4 -> imem_error=1, DONE, no further mem_req.
- rst_n low during FETCHN of jXX -> all outputs at reset values immediately. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> imem_error=1 after 16 cycles.
